// File: rtl/instr_encoder_pkg.sv
// Shared ISA codes, request class encodings and the instruction encoder function.
// Also holds the FIFO occupancy state type used by instr_fifo.
package instr_encoder_pkg;

   localparam logic [2:0] CLS_R      = 3'd0;
   localparam logic [2:0] CLS_I      = 3'd1;
   localparam logic [2:0] CLS_J      = 3'd2;
   localparam logic [2:0] CLS_REGIMM = 3'd3;
   localparam logic [2:0] CLS_NOP    = 3'd4;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [4:0] RT_BLTZ    = 5'h00;
   localparam logic [4:0] RT_BGEZ    = 5'h01;

   typedef enum logic [1:0] {
      FIFO_EMPTY = 2'd0,
      FIFO_BUSY  = 2'd1,
      FIFO_FULL  = 2'd2
   } fifo_state_e;

   typedef struct packed {
      logic        legal;
      logic [31:0] word;
   } enc_result_t;

   function automatic enc_result_t encode(
      input logic [2:0]  cls,
      input logic [5:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  sh,
      input logic [15:0] imm,
      input logic [25:0] tgt
   );
      enc_result_t res;
      res.legal = 1'b0;
      res.word  = 32'h0000_0000;
      case (cls)
         CLS_R: begin
            res.legal = 1'b1;
            res.word  = {OP_SPECIAL, rs, rt, rd, sh, op};
         end
         CLS_I: begin
            res.legal = 1'b1;
            res.word  = {op, rs, rt, imm};
         end
         CLS_J: begin
            res.legal = 1'b1;
            res.word  = {op, tgt};
         end
         CLS_REGIMM: begin
            // Only BLTZ/BGEZ rt codes are supported; op[5] must be clear.
            if (!op[5] && (op[4:0] == RT_BLTZ || op[4:0] == RT_BGEZ)) begin
               res.legal = 1'b1;
               res.word  = {OP_REGIMM, rs, op[4:0], imm};
            end else begin
               res.legal = 1'b0;
               res.word  = 32'h0000_0000;
            end
         end
         CLS_NOP: begin
            res.legal = 1'b1;
            res.word  = 32'h0000_0000;
         end
         default: begin
            res.legal = 1'b0;
            res.word  = 32'h0000_0000;
         end
      endcase
      return res;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request, control and memory-write signals of the instruction encoder.
// Names are from the encoder's point of view (slave modport = encoder).
interface instr_encoder_if;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_class_3;
   logic [5:0]  i_op_type_6;
   logic [4:0]  i_rs_addr_5;
   logic [4:0]  i_rt_addr_5;
   logic [4:0]  i_rd_addr_5;
   logic [4:0]  i_sh_amt_5;
   logic [15:0] i_imm_16;
   logic [25:0] i_target_26;
   logic [31:0] i_base_addr_32;
   logic        i_load;
   logic        i_flush;
   logic        o_wr_en;
   logic [31:0] o_wr_addr_32;
   logic [31:0] o_wr_data_32;
   logic        i_wr_ready;
   logic        o_illegal;
   logic [15:0] o_count_16;

   modport slave (
      input  i_valid, i_class_3, i_op_type_6, i_rs_addr_5, i_rt_addr_5,
             i_rd_addr_5, i_sh_amt_5, i_imm_16, i_target_26, i_base_addr_32,
             i_load, i_flush, i_wr_ready,
      output o_ready, o_wr_en, o_wr_addr_32, o_wr_data_32, o_illegal, o_count_16
   );

   modport master (
      output i_valid, i_class_3, i_op_type_6, i_rs_addr_5, i_rt_addr_5,
             i_rd_addr_5, i_sh_amt_5, i_imm_16, i_target_26, i_base_addr_32,
             i_load, i_flush, i_wr_ready,
      input  o_ready, o_wr_en, o_wr_addr_32, o_wr_data_32, o_illegal, o_count_16
   );
endinterface

// File: rtl/instr_fifo.sv
// Small synchronous FIFO with registered occupancy and EMPTY/BUSY/FULL state.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_occ;
   logic [CW-1:0]    w_occ_nxt;
   fifo_state_e      r_state;
   fifo_state_e      w_state_nxt;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && !i_flush && (r_state != FIFO_FULL);
   assign w_pop  = i_pop && !i_flush && (r_state != FIFO_EMPTY);
   assign o_head = r_mem[r_rd_ptr];

   // Next occupancy: flush clears, a balanced push/pop leaves it unchanged.
   always_comb begin
      w_occ_nxt = r_occ;
      if (i_flush) begin
         w_occ_nxt = {CW{1'b0}};
      end else if (w_push && !w_pop) begin
         w_occ_nxt = r_occ + CW'(1);
      end else if (w_pop && !w_push) begin
         w_occ_nxt = r_occ - CW'(1);
      end else begin
         w_occ_nxt = r_occ;
      end
   end

   // Next state derived from next occupancy.
   always_comb begin
      w_state_nxt = FIFO_BUSY;
      if (w_occ_nxt == CW'(0)) begin
         w_state_nxt = FIFO_EMPTY;
      end else if (w_occ_nxt == CW'(DEPTH)) begin
         w_state_nxt = FIFO_FULL;
      end else begin
         w_state_nxt = FIFO_BUSY;
      end
   end

   // State and occupancy registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= FIFO_EMPTY;
         r_occ   <= {CW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_occ   <= w_occ_nxt;
      end
   end

   // Status outputs decoded from the registered state.
   always_comb begin
      o_full  = 1'b0;
      o_empty = 1'b0;
      case (r_state)
         FIFO_EMPTY: o_empty = 1'b1;
         FIFO_BUSY:  o_empty = 1'b0;
         FIFO_FULL:  o_full  = 1'b1;
         default:    o_empty = 1'b1;
      endcase
   end

   // Storage and pointers; flush rewinds both pointers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else if (i_flush) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into 32-bit words and streams them, through a
// 4-entry FIFO, into instruction memory at an auto-incrementing address.
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   instr_encoder_if.slave bus
);

   enc_result_t w_enc;
   logic        w_full;
   logic        w_empty;
   logic [31:0] w_head;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_reject_req;
   logic        w_reject_load;
   logic        w_do_load;
   logic [31:0] w_base_aligned;
   logic [31:0] r_wr_addr;
   logic [15:0] r_count;
   logic        r_illegal;

   assign w_enc = encode(bus.i_class_3, bus.i_op_type_6, bus.i_rs_addr_5,
                         bus.i_rt_addr_5, bus.i_rd_addr_5, bus.i_sh_amt_5,
                         bus.i_imm_16, bus.i_target_26);

   assign bus.o_ready = !reset && !w_full && !bus.i_load && !bus.i_flush;
   assign bus.o_wr_en = !reset && !w_empty;

   assign w_accept       = bus.i_valid && bus.o_ready;
   assign w_push         = w_accept && w_enc.legal;
   assign w_reject_req   = w_accept && !w_enc.legal;
   // Flush outranks load; a load that loses to flush is silently dropped.
   assign w_do_load      = bus.i_load && !bus.i_flush && w_empty;
   assign w_reject_load  = bus.i_load && !bus.i_flush && !w_empty;
   assign w_pop          = bus.o_wr_en && bus.i_wr_ready && !bus.i_flush;
   assign w_base_aligned = bus.i_base_addr_32 & ~32'h0000_0003;

   instr_fifo #(
      .DEPTH (4),
      .WIDTH (32)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_flush     (bus.i_flush),
      .i_push      (w_push),
      .i_push_data (w_enc.word),
      .i_pop       (w_pop),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head)
   );

   // Write address, written-word count and the rejection pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_addr <= 32'h0000_0000;
         r_count   <= 16'h0000;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_reject_req || w_reject_load;
         if (w_do_load) begin
            r_wr_addr <= w_base_aligned;
         end else if (w_pop) begin
            r_wr_addr <= r_wr_addr + 32'd4;
         end
         if (w_pop) begin
            r_count <= r_count + 16'd1;
         end
      end
   end

   assign bus.o_wr_addr_32 = r_wr_addr;
   assign bus.o_wr_data_32 = w_head;
   assign bus.o_count_16   = r_count;
   assign bus.o_illegal    = r_illegal;

endmodule
